// File: rtl/sdr_req_arb_if.sv
// sdr_req_arb_if: engine <-> arbiter handshake bundle for the SDRAM controller.
// master: engine side (drives requests/exits, observes grants).
// slave:  arbiter side (sdr_req_arb).
interface sdr_req_arb_if;
  logic       init_done;
  logic       wr_req;
  logic       rd_req;
  logic       wr_pausing;
  logic       wr_exit;
  logic       rd_exit;
  logic       aref_done;
  logic       grant_init;
  logic       grant_wr;
  logic       grant_rd;
  logic       grant_aref;
  logic       aref_req;
  logic [2:0] ref_pend;
  logic       ref_ovf;

  modport master (
    output init_done, wr_req, rd_req, wr_pausing, wr_exit, rd_exit, aref_done,
    input  grant_init, grant_wr, grant_rd, grant_aref, aref_req, ref_pend, ref_ovf
  );

  modport slave (
    input  init_done, wr_req, rd_req, wr_pausing, wr_exit, rd_exit, aref_done,
    output grant_init, grant_wr, grant_rd, grant_aref, aref_req, ref_pend, ref_ovf
  );
endinterface

// File: rtl/sdr_req_arb.sv
// sdr_req_arb: SDRAM pin-ownership arbiter and refresh scheduler.
// Grants init/write/read/auto-refresh one at a time as a decode of the state
// register, owns the refresh interval timer and the pending-refresh counter.
// Optional feature: define SDR_ARB_RR_EN for write/read round-robin on ties;
// otherwise write has fixed priority over read.
module sdr_req_arb #(
  parameter int unsigned REF_PERIOD   = 1300,
  parameter int unsigned REF_MAX_PEND = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  sdr_req_arb_if.slave bus
);
  localparam int unsigned TMR_W  = 12;
  localparam int unsigned PEND_W = 3;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(REF_PERIOD - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(REF_MAX_PEND);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_AREF  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TMR_W-1:0]    r_timer;
  logic [PEND_W-1:0]   r_ref_pend;
  logic                r_ref_ovf;
  logic                r_last_wr;
  logic                w_tick;
  logic                w_dec;
  logic                w_pick_wr;

  // Tick on the timer wrap; timer is frozen at zero until init completes.
  assign w_tick = (r_state != ST_INIT) && (r_timer == TMR_LAST);
  // A done pulse with nothing pending is dropped so the counter cannot underflow.
  assign w_dec  = bus.aref_done && (r_ref_pend != '0);

`ifdef SDR_ARB_RR_EN
  // Tie goes to the engine not served last; a lone requester always wins.
  assign w_pick_wr = bus.wr_req && (!bus.rd_req || !r_last_wr);
`else
  // Fixed priority: write over read. last_wr is kept but not consulted.
  logic w_last_wr_unused;
  assign w_last_wr_unused = r_last_wr;
  assign w_pick_wr        = bus.wr_req;
`endif

  // Refresh interval timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_timer <= '0;
    else if (r_state == ST_INIT) r_timer <= '0;
    else if (w_tick)            r_timer <= '0;
    else                        r_timer <= r_timer + TMR_W'(1);
  end

  // Pending-refresh counter with saturation and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_pend <= '0;
      r_ref_ovf  <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_ref_pend <= '0;
    end else if (w_tick && !w_dec) begin
      if (r_ref_pend == PEND_MAX) r_ref_ovf  <= 1'b1;
      else                        r_ref_pend <= r_ref_pend + PEND_W'(1);
    end else if (w_dec && !w_tick) begin
      r_ref_pend <= r_ref_pend - PEND_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  // Next-state: every grant returns through IDLE, refresh first in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (bus.init_done) w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (r_ref_pend != '0)    w_state_nxt = ST_AREF;
        else if (bus.wr_pausing) w_state_nxt = ST_WRITE;
        else if (w_pick_wr)      w_state_nxt = ST_WRITE;
        else if (bus.rd_req)     w_state_nxt = ST_READ;
      end
      ST_WRITE: if (bus.wr_exit)   w_state_nxt = ST_IDLE;
      ST_READ:  if (bus.rd_exit)   w_state_nxt = ST_IDLE;
      ST_AREF:  if (bus.aref_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  // Remember which data engine was entered most recently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_last_wr <= 1'b0;
    else if ((w_state_nxt == ST_WRITE) && (r_state != ST_WRITE))
      r_last_wr <= 1'b1;
    else if ((w_state_nxt == ST_READ) && (r_state != ST_READ))
      r_last_wr <= 1'b0;
  end

  // Outputs: pure decodes of registers.
  assign bus.grant_init = (r_state == ST_INIT);
  assign bus.grant_wr   = (r_state == ST_WRITE);
  assign bus.grant_rd   = (r_state == ST_READ);
  assign bus.grant_aref = (r_state == ST_AREF);
  assign bus.aref_req   = (r_ref_pend != '0);
  assign bus.ref_pend   = r_ref_pend;
  assign bus.ref_ovf    = r_ref_ovf;
endmodule

// File: tb/tb_sdr_req_arb.sv
// tb_sdr_req_arb: scoreboard bench for sdr_req_arb (REF_PERIOD=16, REF_MAX_PEND=2).
// Stimulus pushes expected grant order and per-cycle status; monitors compare.
module tb_sdr_req_arb;
  localparam logic [3:0] G_NONE = 4'b0000;
  localparam logic [3:0] G_INIT = 4'b0001;
  localparam logic [3:0] G_WR   = 4'b0010;
  localparam logic [3:0] G_RD   = 4'b0100;
  localparam logic [3:0] G_AREF = 4'b1000;
`ifdef SDR_ARB_RR_EN
  localparam logic [3:0] G_ALT  = G_RD;
`else
  localparam logic [3:0] G_ALT  = G_WR;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic [2:0] p;
    logic       ovf;
  } st_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   r0    = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [3:0] gq[$];
  st_t        sq[$];

  sdr_req_arb_if bus ();

  sdr_req_arb #(.REF_PERIOD(16), .REF_MAX_PEND(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] grants();
    return {bus.grant_aref, bus.grant_rd, bus.grant_wr, bus.grant_init};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc - r0);
    end
  endtask

  // Expected status at release-relative cycle k; aref_req follows ref_pend.
  task automatic exp_st(input int k, input logic [3:0] g, input logic [2:0] p, input logic ovf);
    st_t e;
    e.cyc = r0 + k;
    e.g   = g;
    e.p   = p;
    e.ovf = ovf;
    sq.push_back(e);
  endtask

  // Advance to just after the edge that starts release-relative cycle k.
  task automatic at(input int k);
    while (cyc < r0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Grant monitor: each newly raised grant must be the next one expected.
  initial begin : grant_mon
    logic [3:0] g;
    logic [3:0] prev_g;
    logic [3:0] exp_g;
    prev_g = G_NONE;
    forever begin
      @(negedge clk);
      g = grants();
      if (g !== prev_g && g !== G_NONE) begin
        if (gq.size() == 0) begin
          check("unexpected_grant", 32'(g), 32'(G_NONE));
        end else begin
          exp_g = gq.pop_front();
          check("grant_seq", 32'(g), 32'(exp_g));
        end
        check("grant_onehot", 32'($onehot(g)), 32'd1);
        if (rst_n) check("idle_dwell", 32'(prev_g), 32'(G_NONE));
      end
      prev_g = g;
    end
  end

  // Status monitor: {grants, ref_pend, aref_req, ref_ovf} at scheduled cycles.
  initial begin : stat_mon
    st_t e;
    forever begin
      @(negedge clk);
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        e = sq.pop_front();
        if (e.cyc != cyc)
          check($sformatf("status_missed@%0d", e.cyc - r0), 32'(cyc - r0), 32'(e.cyc - r0));
        else
          check($sformatf("status@%0d", e.cyc - r0),
                32'({grants(), bus.ref_pend, bus.aref_req, bus.ref_ovf}),
                32'({e.g, e.p, (e.p != 3'd0), e.ovf}));
      end
    end
  end

  initial begin : stim
    bus.init_done  = 1'b0;
    bus.wr_req     = 1'b0;
    bus.rd_req     = 1'b0;
    bus.wr_pausing = 1'b0;
    bus.wr_exit    = 1'b0;
    bus.rd_exit    = 1'b0;
    bus.aref_done  = 1'b0;
    gq.push_back(G_INIT);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0    = cyc;

    // Reset/init and first tick.
    exp_st(5, G_INIT, 3'd0, 1'b0);
    exp_st(10, G_INIT, 3'd0, 1'b0);
    at(10); bus.init_done = 1'b1;
    exp_st(11, G_NONE, 3'd0, 1'b0);
    exp_st(26, G_NONE, 3'd0, 1'b0);
    exp_st(27, G_NONE, 3'd1, 1'b0);

    // Refresh beats both requests; then tie goes to write.
    at(27); bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    gq.push_back(G_AREF);
    exp_st(28, G_AREF, 3'd1, 1'b0);
    at(30); bus.aref_done = 1'b1;
    gq.push_back(G_WR);
    exp_st(31, G_NONE, 3'd0, 1'b0);
    exp_st(32, G_WR, 3'd0, 1'b0);
    exp_st(43, G_WR, 3'd1, 1'b0);
    at(31); bus.aref_done = 1'b0;

    // Write pause for refresh, then resume ahead of the read request.
    at(44); bus.wr_exit = 1'b1; bus.wr_pausing = 1'b1; bus.wr_req = 1'b0;
    gq.push_back(G_AREF);
    gq.push_back(G_WR);
    exp_st(45, G_NONE, 3'd1, 1'b0);
    exp_st(46, G_AREF, 3'd1, 1'b0);
    at(45); bus.wr_exit = 1'b0;
    at(48); bus.aref_done = 1'b1;
    exp_st(49, G_NONE, 3'd0, 1'b0);
    exp_st(50, G_WR, 3'd0, 1'b0);
    at(49); bus.aref_done = 1'b0;
    at(50); bus.wr_pausing = 1'b0;

    // Long read: pending saturates at 2, third tick sets overflow.
    at(52); bus.wr_exit = 1'b1;
    gq.push_back(G_RD);
    exp_st(53, G_NONE, 3'd0, 1'b0);
    exp_st(54, G_RD, 3'd0, 1'b0);
    exp_st(59, G_RD, 3'd1, 1'b0);
    exp_st(75, G_RD, 3'd2, 1'b0);
    exp_st(90, G_RD, 3'd2, 1'b0);
    exp_st(91, G_RD, 3'd2, 1'b1);
    at(53); bus.wr_exit = 1'b0;
    at(100); bus.rd_exit = 1'b1; bus.rd_req = 1'b0;
    gq.push_back(G_AREF);
    exp_st(101, G_NONE, 3'd2, 1'b1);
    exp_st(102, G_AREF, 3'd2, 1'b1);
    at(101); bus.rd_exit = 1'b0;

    // Done coincident with tick leaves pending at 2; drain the rest.
    at(106); bus.aref_done = 1'b1;
    gq.push_back(G_AREF);
    exp_st(106, G_AREF, 3'd2, 1'b1);
    exp_st(107, G_NONE, 3'd2, 1'b1);
    exp_st(108, G_AREF, 3'd2, 1'b1);
    at(107); bus.aref_done = 1'b0;
    at(110); bus.aref_done = 1'b1;
    gq.push_back(G_AREF);
    exp_st(111, G_NONE, 3'd1, 1'b1);
    exp_st(112, G_AREF, 3'd1, 1'b1);
    at(111); bus.aref_done = 1'b0;
    at(114); bus.aref_done = 1'b1;
    exp_st(115, G_NONE, 3'd0, 1'b1);
    at(115); bus.aref_done = 1'b0;

    // Both requests held, 4-cycle grants; a refresh lands in the middle.
    at(116); bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    gq.push_back(G_WR);
    gq.push_back(G_ALT);
    gq.push_back(G_AREF);
    gq.push_back(G_WR);
    gq.push_back(G_ALT);
    gq.push_back(G_AREF);
    exp_st(117, G_WR, 3'd0, 1'b1);
    exp_st(122, G_ALT, 3'd0, 1'b1);
    exp_st(123, G_ALT, 3'd1, 1'b1);
    exp_st(127, G_AREF, 3'd1, 1'b1);
    exp_st(131, G_WR, 3'd0, 1'b1);
    exp_st(136, G_ALT, 3'd0, 1'b1);
    exp_st(140, G_NONE, 3'd1, 1'b1);
    exp_st(141, G_AREF, 3'd1, 1'b1);
    exp_st(144, G_NONE, 3'd0, 1'b1);
    at(120); bus.wr_exit = 1'b1; bus.rd_exit = 1'b1;
    at(121); bus.wr_exit = 1'b0; bus.rd_exit = 1'b0;
    at(125); bus.wr_exit = 1'b1; bus.rd_exit = 1'b1;
    at(126); bus.wr_exit = 1'b0; bus.rd_exit = 1'b0;
    at(129); bus.aref_done = 1'b1;
    at(130); bus.aref_done = 1'b0;
    at(134); bus.wr_exit = 1'b1; bus.rd_exit = 1'b1;
    at(135); bus.wr_exit = 1'b0; bus.rd_exit = 1'b0;
    at(139); bus.wr_exit = 1'b1; bus.rd_exit = 1'b1; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    at(140); bus.wr_exit = 1'b0; bus.rd_exit = 1'b0;
    at(143); bus.aref_done = 1'b1;

    // Async reset in the middle of a write.
    at(144); bus.aref_done = 1'b0; bus.wr_req = 1'b1;
    gq.push_back(G_WR);
    exp_st(145, G_WR, 3'd0, 1'b1);
    exp_st(146, G_WR, 3'd0, 1'b1);
    at(147);
    gq.push_back(G_INIT);
    rst_n = 1'b0; bus.wr_req = 1'b0;
    exp_st(147, G_INIT, 3'd0, 1'b0);
    exp_st(148, G_INIT, 3'd0, 1'b0);
    at(149); rst_n = 1'b1;
    exp_st(149, G_INIT, 3'd0, 1'b0);
    exp_st(150, G_NONE, 3'd0, 1'b0);
    at(153);

    check("grant_queue_drained", 32'(gq.size()), 32'd0);
    check("status_queue_drained", 32'(sq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
